// File: rtl/csr_access_unit.sv
// csr_access_unit: runs one Zicsr instruction (read / merge / write) against
// the CSR file's en/we/busy handshake and reports old value, illegal or timeout.
//
// Ports:
//   clk_i, rstn_i        clock, async active-low reset
//   req_i .. rd_zero_i   decoded instruction, accepted on req_i & ready_o
//   ready_o, done_o      idle indication, one-cycle completion pulse
//   rd_data_o            old CSR value (valid with done_o)
//   illegal_o, timeout_o completion status (valid with done_o)
//   csr_en_o .. csr_ro_i CSR file strobe, address, data and status
module csr_access_unit #(
   parameter int CSR_DATA_WIDTH = 32,
   parameter int CSR_ADDR_WIDTH = 12,
   parameter int CSR_TIMEOUT    = 16
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      req_i,
   input  logic [2:0]                op_i,
   input  logic [CSR_ADDR_WIDTH-1:0] addr_i,
   input  logic [CSR_DATA_WIDTH-1:0] rs1_val_i,
   input  logic [4:0]                uimm_i,
   input  logic                      rs1_zero_i,
   input  logic                      rd_zero_i,
   output logic                      ready_o,
   output logic                      done_o,
   output logic [CSR_DATA_WIDTH-1:0] rd_data_o,
   output logic                      illegal_o,
   output logic                      timeout_o,
   output logic                      csr_en_o,
   output logic                      csr_we_o,
   output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
   output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
   input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
   input  logic                      csr_busy_i,
   input  logic                      csr_exists_i,
   input  logic                      csr_ro_i
);

   localparam int CW = $clog2(CSR_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, CHECK, RD_ISSUE, RD_WAIT,
      WR_ISSUE, WR_WAIT, DONE
   } state_t;

   state_t state_q, state_d;

   logic [1:0]                kind_q;
   logic [CSR_ADDR_WIDTH-1:0] addr_q;
   logic [CSR_DATA_WIDTH-1:0] src_q;
   logic [CSR_DATA_WIDTH-1:0] old_q;
   logic [CSR_DATA_WIDTH-1:0] new_val;
   logic                      need_rd_q;
   logic                      need_wr_q;
   logic                      seen_q;
   logic [CW-1:0]             cnt_q;
   logic                      illegal_q;
   logic                      timeout_q;

   logic wait_st;
   logic complete;
   logic expired;
   logic ill_chk;
   logic acc_rw;

   assign wait_st  = (state_q == RD_WAIT) || (state_q == WR_WAIT);
   // completion needs a busy pulse seen earlier in this wait state
   assign complete = seen_q & ~csr_busy_i;
   assign expired  = (cnt_q == CW'(CSR_TIMEOUT - 1));
   assign ill_chk  = (kind_q == 2'b00) | ~csr_exists_i
                   | (csr_ro_i & need_wr_q);
   assign acc_rw   = (op_i[1:0] == 2'b01);
   assign csr_addr_o = addr_q;

   always_comb begin
      new_val = src_q;
      unique case (1'b1)
         kind_q == 2'b10: new_val = old_q | src_q;
         kind_q == 2'b11: new_val = old_q & ~src_q;
         default:         new_val = src_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      ready_o    = 1'b0;
      done_o     = 1'b0;
      csr_en_o   = 1'b0;
      csr_we_o   = 1'b0;
      csr_data_o = '0;
      rd_data_o  = '0;
      illegal_o  = 1'b0;
      timeout_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (req_i) state_d = CHECK;
         end
         CHECK: begin
            if (ill_chk)        state_d = DONE;
            else if (need_rd_q) state_d = RD_ISSUE;
            else                state_d = WR_ISSUE;
         end
         RD_ISSUE: begin
            // hold off while a previous access still keeps the file busy
            if (!csr_busy_i) begin
               csr_en_o = 1'b1;
               state_d  = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (complete)
               state_d = need_wr_q ? WR_ISSUE : DONE;
            else if (expired)
               state_d = DONE;
         end
         WR_ISSUE: begin
            csr_we_o   = 1'b1;
            csr_data_o = new_val;
            if (!csr_busy_i) begin
               csr_en_o = 1'b1;
               state_d  = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (complete || expired) state_d = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            rd_data_o = old_q;
            illegal_o = illegal_q;
            timeout_o = timeout_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         kind_q    <= '0;
         addr_q    <= '0;
         src_q     <= '0;
         old_q     <= '0;
         need_rd_q <= 1'b0;
         need_wr_q <= 1'b0;
         seen_q    <= 1'b0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == IDLE && req_i) begin
            kind_q    <= op_i[1:0];
            addr_q    <= addr_i;
            src_q     <= op_i[2] ? CSR_DATA_WIDTH'(uimm_i)
                                 : rs1_val_i;
            need_rd_q <= ~(acc_rw & rd_zero_i);
            need_wr_q <= acc_rw | (op_i[2] ? (uimm_i != 5'd0)
                                            : ~rs1_zero_i);
            old_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
         end
         if (state_q == CHECK) illegal_q <= ill_chk;
         if (wait_st) begin
            seen_q <= seen_q | csr_busy_i;
            cnt_q  <= cnt_q + 1'b1;
         end else begin
            seen_q <= 1'b0;
            cnt_q  <= '0;
         end
         if (state_q == RD_WAIT && complete) old_q <= csr_data_i;
         if (wait_st && !complete && expired) begin
            timeout_q <= 1'b1;
            old_q     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed + random Zicsr accesses against a small
// CSR file model, checked against a spec-level reference model.
module tb_csr_access_unit;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int TO = 16;

   localparam logic [15:0] EXISTS = 16'b0000_0000_1011_1111;
   localparam logic [15:0] RO     = 16'b0000_0000_0011_0000;
   localparam logic [31:0] INIT [16] = '{
      32'h8, 32'hFF, 32'h1234, 32'h0,
      32'hDEAD, 32'h55, 32'h0, 32'hCAFE,
      32'h0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0};

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          req_i = 1'b0;
   logic [2:0]    op_i = '0;
   logic [AW-1:0] addr_i = '0;
   logic [DW-1:0] rs1_val_i = '0;
   logic [4:0]    uimm_i = '0;
   logic          rs1_zero_i = 1'b0;
   logic          rd_zero_i = 1'b0;
   logic          ready_o, done_o, illegal_o, timeout_o;
   logic [DW-1:0] rd_data_o;
   logic          csr_en_o, csr_we_o;
   logic [AW-1:0] csr_addr_o;
   logic [DW-1:0] csr_data_o;
   logic [DW-1:0] csr_data_i = '0;
   logic          csr_busy_i, csr_exists_i, csr_ro_i;

   int errors = 0;
   int checks = 0;

   logic [31:0] dev_mem [16] = INIT;
   logic [31:0] exp_mem [16] = INIT;
   int busy_left = 0;
   int stretch = 1;
   bit mute = 1'b0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   logic [31:0] wr_data = '0;

   csr_access_unit #(
      .CSR_DATA_WIDTH(DW), .CSR_ADDR_WIDTH(AW),
      .CSR_TIMEOUT(TO)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i),
      .op_i(op_i), .addr_i(addr_i), .rs1_val_i(rs1_val_i),
      .uimm_i(uimm_i), .rs1_zero_i(rs1_zero_i),
      .rd_zero_i(rd_zero_i), .ready_o(ready_o),
      .done_o(done_o), .rd_data_o(rd_data_o),
      .illegal_o(illegal_o), .timeout_o(timeout_o),
      .csr_en_o(csr_en_o), .csr_we_o(csr_we_o),
      .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o),
      .csr_data_i(csr_data_i), .csr_busy_i(csr_busy_i),
      .csr_exists_i(csr_exists_i), .csr_ro_i(csr_ro_i)
   );

   always #5 clk_i = ~clk_i;

   // CSR file: busy for `stretch` cycles after each strobe
   always @(posedge clk_i) begin
      if (busy_left > 0) busy_left <= busy_left - 1;
      if (csr_en_o && !mute) begin
         busy_left  <= stretch;
         csr_data_i <= dev_mem[csr_addr_o[3:0]];
         if (csr_we_o) dev_mem[csr_addr_o[3:0]] <= csr_data_o;
      end
   end

   assign csr_busy_i   = (busy_left > 0);
   assign csr_exists_i = EXISTS[csr_addr_o[3:0]];
   assign csr_ro_i     = RO[csr_addr_o[3:0]];

   always @(negedge clk_i) begin
      if (csr_en_o) begin
         if (csr_we_o) begin
            wr_cnt++;
            wr_data = csr_data_o;
         end else begin
            rd_cnt++;
         end
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic do_op(input string name,
                        input logic [2:0] op,
                        input int idx,
                        input logic [31:0] rs1,
                        input logic [4:0] uimm,
                        input logic rs1z,
                        input logic rdz);
      logic [1:0]  kind;
      logic [31:0] src, old, nv, exp_rd;
      bit need_rd, need_wr, ill, exp_to;
      int exp_nr, exp_nw, lat, n, r0, w0;
      bit got;
      kind    = op[1:0];
      src     = op[2] ? {27'b0, uimm} : rs1;
      need_rd = !(kind == 2'd1 && rdz);
      need_wr = (kind == 2'd1) ||
                (op[2] ? (uimm != 5'd0) : !rs1z);
      ill     = (kind == 2'd0) || !EXISTS[idx] ||
                (RO[idx] && need_wr);
      old     = exp_mem[idx];
      case (kind)
         2'd1:    nv = src;
         2'd2:    nv = old | src;
         default: nv = old & ~src;
      endcase
      exp_rd = '0;
      exp_to = 1'b0;
      exp_nr = 0;
      exp_nw = 0;
      if (ill) begin
         lat = 2;
      end else if (mute) begin
         exp_to = 1'b1;
         lat = 3 + TO;
         if (need_rd) exp_nr = 1;
         else         exp_nw = 1;
      end else begin
         exp_nr = need_rd ? 1 : 0;
         exp_nw = need_wr ? 1 : 0;
         exp_rd = need_rd ? old : '0;
         lat = 2 + (exp_nr + exp_nw) * (stretch + 2);
         if (need_wr) exp_mem[idx] = nv;
      end

      @(negedge clk_i);
      check({name, ".ready"}, {31'b0, ready_o}, 32'd1);
      req_i      = 1'b1;
      op_i       = op;
      addr_i     = {8'h30, idx[3:0]};
      rs1_val_i  = rs1;
      uimm_i     = uimm;
      rs1_zero_i = rs1z;
      rd_zero_i  = rdz;
      r0 = rd_cnt;
      w0 = wr_cnt;
      @(posedge clk_i);
      n = 0;
      got = 1'b0;
      while (n < 200 && !got) begin
         @(negedge clk_i);
         n++;
         req_i = 1'b0;
         if (done_o) got = 1'b1;
      end
      check({name, ".done"}, {31'b0, got}, 32'd1);
      if (got) begin
         check({name, ".lat"}, n, lat);
         check({name, ".rd"}, rd_data_o, exp_rd);
         check({name, ".ill"}, {31'b0, illegal_o}, {31'b0, ill});
         check({name, ".to"}, {31'b0, timeout_o}, {31'b0, exp_to});
         check({name, ".nrd"}, rd_cnt - r0, exp_nr);
         check({name, ".nwr"}, wr_cnt - w0, exp_nw);
         if (exp_nw != 0)
            check({name, ".wdata"}, wr_data, nv);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      repeat (2) @(negedge clk_i);
      check("rst.ready", {31'b0, ready_o}, 32'd1);
      check("rst.done", {31'b0, done_o}, 32'd0);
      check("rst.en", {31'b0, csr_en_o}, 32'd0);
      check("rst.addr", {20'b0, csr_addr_o}, 32'd0);
      check("rst.rd", rd_data_o, 32'd0);
      rstn_i = 1'b1;

      // directed cases
      do_op("t1_rs_x0", 3'b010, 0, 32'h0, 5'd0, 1'b1, 1'b0);
      do_op("t2_rc", 3'b011, 1, 32'h0F, 5'd0, 1'b0, 1'b0);
      do_op("t3_rwi", 3'b101, 3, 32'h0, 5'd5, 1'b0, 1'b1);
      do_op("t4_noex", 3'b001, 6, 32'h77, 5'd0, 1'b0, 1'b0);
      do_op("t4_ro", 3'b001, 4, 32'h77, 5'd0, 1'b0, 1'b0);
      do_op("t4_op100", 3'b100, 0, 32'h0, 5'd3, 1'b0, 1'b0);
      do_op("t4_ro_rd", 3'b010, 5, 32'h0, 5'd0, 1'b1, 1'b0);
      do_op("t4_rsi0", 3'b110, 4, 32'h0, 5'd0, 1'b0, 1'b0);

      mute = 1'b1;
      do_op("t5_tmo", 3'b010, 2, 32'hF0, 5'd0, 1'b0, 1'b0);
      mute = 1'b0;

      // reset while the write is in flight
      @(negedge clk_i);
      w0 = wr_cnt;
      req_i = 1'b1; op_i = 3'b001; addr_i = 12'h302;
      rs1_val_i = 32'hA5; rs1_zero_i = 1'b0; rd_zero_i = 1'b1;
      @(posedge clk_i);
      repeat (3) begin
         @(negedge clk_i);
         req_i = 1'b0;
      end
      check("t6.wstrobe", wr_cnt - w0, 1);
      exp_mem[2] = 32'hA5;
      rstn_i = 1'b0;
      #1;
      check("t6.ready", {31'b0, ready_o}, 32'd1);
      check("t6.en", {31'b0, csr_en_o}, 32'd0);
      check("t6.we", {31'b0, csr_we_o}, 32'd0);
      check("t6.addr", {20'b0, csr_addr_o}, 32'd0);
      check("t6.done", {31'b0, done_o}, 32'd0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      do_op("t6_after", 3'b010, 2, 32'h0, 5'd0, 1'b1, 1'b0);

      // random traffic
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] rs1;
         logic [4:0]  uimm;
         logic        rs1z, rdz;
         int          idx;
         op   = 3'($urandom_range(0, 7));
         idx  = $urandom_range(0, 7);
         rs1z = ($urandom_range(0, 3) == 0);
         rs1  = rs1z ? 32'h0 : $urandom;
         uimm = ($urandom_range(0, 3) == 0) ? 5'd0
                : 5'($urandom_range(1, 31));
         rdz  = ($urandom_range(0, 3) == 0);
         stretch = $urandom_range(1, 3);
         do_op($sformatf("rnd%0d", i), op, idx, rs1, uimm,
               rs1z, rdz);
      end
      stretch = 1;
      repeat (5) @(negedge clk_i);

      for (int k = 0; k < 8; k++)
         check($sformatf("mem%0d", k), dev_mem[k], exp_mem[k]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
